// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: accepts one CPU load/store, completes it after
// LATENCY cycles with a one-cycle memReady pulse, backed by a byte-lane RAM.
module data_mem_ctrl #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    input  logic        wen,
    input  logic        ren,
    input  logic [3:0]  byte_select_vector,
    output logic        memReady,
    output logic [31:0] dataout,
    output logic        access_fault
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [31:0]           wdata_q;
    logic [3:0]            bsv_q;
    logic                  write_q;
    logic                  hit_q;
    logic                  mem_ready_q;
    logic                  fault_q;
    logic [31:0]           dataout_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  req;
    logic                  in_hit;
    logic                  commit;
    logic                  cur_write;
    logic                  cur_hit;
    logic [ADDR_WIDTH-1:0] cur_word;
    logic [31:0]           cur_data;
    logic [3:0]            cur_bsv;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];
    assign in_hit = (address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // The access commits on the edge entering DONE; with LATENCY=1 that is the
    // accepting edge itself, so the live inputs are used instead of the latches.
    // NOTE: combinational logic uses blocking '=' and defaults every output first so no latch is inferred.
    always_comb begin
        req       = ren | wen;
        cur_write = write_q;
        cur_hit   = hit_q;
        cur_word  = word_q;
        cur_data  = wdata_q;
        cur_bsv   = bsv_q;
        if (state_q == S_IDLE) begin
            cur_write = wen;
            cur_hit   = in_hit;
            cur_word  = address[ADDR_WIDTH+1:2];
            cur_data  = datain;
            cur_bsv   = byte_select_vector;
        end
        commit = ((state_q == S_IDLE) && req && (LATENCY == 1)) ||
                 ((state_q == S_WAIT) && (cnt_q == 4'd0));
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            word_q      <= '0;
            wdata_q     <= '0;
            bsv_q       <= 4'd0;
            write_q     <= 1'b0;
            hit_q       <= 1'b0;
            mem_ready_q <= 1'b0;
            fault_q     <= 1'b0;
            dataout_q   <= '0;
        end else begin
            mem_ready_q <= commit;
            fault_q     <= commit && !cur_hit;
            if (commit && !cur_write) begin
                dataout_q <= cur_hit ? mem_q[cur_word] : '0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        word_q  <= address[ADDR_WIDTH+1:2];
                        wdata_q <= datain;
                        bsv_q   <= byte_select_vector;
                        write_q <= wen;
                        hit_q   <= in_hit;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; reset only blocks a pending write from committing.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_write && cur_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_bsv[i]) begin
                    mem_q[cur_word][8*i +: 8] <= cur_data[8*i +: 8];
                end
            end
        end
    end

    assign memReady     = mem_ready_q;
    assign dataout      = dataout_q;
    assign access_fault = fault_q;

endmodule
